// File: rtl/qnr_pipe_divider.sv
// Pipelined unsigned restoring divider for the jpeg_encoder quantizer; one quotient bit per stage.
// Define QNR_ROUND_EN to add a half-up rounding stage (saturating) after the last divide stage.
module qnr_pipe_divider #(
   parameter int DW    = 24,
   parameter int SW    = 16,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_dividend,
   input  logic [SW-1:0]    in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [DW-1:0]    out_quotient,
   output logic [SW-1:0]    out_remainder,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_div0
);

   localparam int NI = DW - 1;

   logic             vld_p  [NI];
   logic [SW:0]      rem_p  [NI];
   logic [DW-1:0]    qd_p   [NI];
   logic [SW-1:0]    dvs_p  [NI];
   logic [TAG_W-1:0] tag_p  [NI];
   logic             div0_p [NI];

   logic [SW:0]      rem_n  [DW];
   logic [DW-1:0]    qd_n   [DW];

   // qd holds the unconsumed dividend bits in its MSBs and the resolved quotient bits in its LSBs.
   // A zero divisor always "succeeds", yielding all-ones and the dividend low bits as remainder.
   function automatic logic [SW+DW:0] div_step(input logic [SW:0]   rem,
                                               input logic [DW-1:0] qd,
                                               input logic [SW-1:0] dvs);
      logic [SW+1:0] sh;
      logic          ge;
      logic [SW:0]   nrem;
      sh   = {rem, qd[DW-1]};
      ge   = (sh >= {2'b00, dvs});
      nrem = ge ? (sh[SW:0] - {1'b0, dvs}) : sh[SW:0];
      return {nrem, qd[DW-2:0], ge};
   endfunction

   for (genvar k = 0; k < DW; k++) begin : g_step
      if (k == 0) begin : g_first
         assign {rem_n[k], qd_n[k]} = div_step({(SW+1){1'b0}}, in_dividend, in_divisor);
      end else begin : g_next
         assign {rem_n[k], qd_n[k]} = div_step(rem_p[k-1], qd_p[k-1], dvs_p[k-1]);
      end
   end

   // ---- divide stages 0..DW-2 ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) vld_p[k] <= 1'b0;
      end else if (ena) begin
         vld_p[0] <= in_valid;
         for (int k = 1; k < NI; k++) vld_p[k] <= vld_p[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (ena) begin
         rem_p[0]  <= rem_n[0];
         qd_p[0]   <= qd_n[0];
         dvs_p[0]  <= in_divisor;
         tag_p[0]  <= in_tag;
         div0_p[0] <= (in_divisor == '0);
         for (int k = 1; k < NI; k++) begin
            rem_p[k]  <= rem_n[k];
            qd_p[k]   <= qd_n[k];
            dvs_p[k]  <= dvs_p[k-1];
            tag_p[k]  <= tag_p[k-1];
            div0_p[k] <= div0_p[k-1];
         end
      end
   end

`ifdef QNR_ROUND_EN
   logic             vld_f;
   logic [DW-1:0]    q_f;
   logic [SW-1:0]    r_f;
   logic [SW-1:0]    dvs_f;
   logic [TAG_W-1:0] tag_f;
   logic             div0_f;

   // Half-up rounding that saturates at all ones; div0 results pass through untouched.
   function automatic logic [DW-1:0] round_sat(input logic [DW-1:0] q,
                                               input logic [SW-1:0] r,
                                               input logic [SW-1:0] dvs,
                                               input logic          div0);
      logic up;
      up = !div0 && ({r, 1'b0} >= {1'b0, dvs}) && !(&q);
      return up ? q + 1'b1 : q;
   endfunction

   // ---- last divide stage ----
   always_ff @(posedge clk) begin
      if (!rst_n)   vld_f <= 1'b0;
      else if (ena) vld_f <= vld_p[NI-1];
   end

   always_ff @(posedge clk) begin
      if (ena) begin
         q_f    <= qd_n[DW-1];
         r_f    <= rem_n[DW-1][SW-1:0];
         dvs_f  <= dvs_p[NI-1];
         tag_f  <= tag_p[NI-1];
         div0_f <= div0_p[NI-1];
      end
   end

   // ---- rounding / output stage ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_tag       <= '0;
         out_div0      <= 1'b0;
      end else if (ena) begin
         out_valid     <= vld_f;
         out_quotient  <= round_sat(q_f, r_f, dvs_f, div0_f);
         out_remainder <= r_f;
         out_tag       <= tag_f;
         out_div0      <= div0_f;
      end
   end
`else
   // ---- last divide stage / output ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_tag       <= '0;
         out_div0      <= 1'b0;
      end else if (ena) begin
         out_valid     <= vld_p[NI-1];
         out_quotient  <= qd_n[DW-1];
         out_remainder <= rem_n[DW-1][SW-1:0];
         out_tag       <= tag_p[NI-1];
         out_div0      <= div0_p[NI-1];
      end
   end
`endif

endmodule

// File: tb/tb_qnr_pipe_divider.sv
// Self-checking bench for qnr_pipe_divider: arithmetic reference model plus directed literal checks.
module tb_qnr_pipe_divider;
   localparam int DW = 8, SW = 8, TAG_W = 4;
`ifdef QNR_ROUND_EN
   localparam int LAT = DW + 1;
`else
   localparam int LAT = DW;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ena = 1'b1;
   logic             in_valid = 1'b0;
   logic [DW-1:0]    in_dividend = '0;
   logic [SW-1:0]    in_divisor = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic [DW-1:0]    out_quotient;
   logic [SW-1:0]    out_remainder;
   logic [TAG_W-1:0] out_tag;
   logic             out_div0;

   always #5 clk = ~clk;

   qnr_pipe_divider #(.DW(DW), .SW(SW), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
      .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
      .out_valid(out_valid), .out_quotient(out_quotient), .out_remainder(out_remainder),
      .out_tag(out_tag), .out_div0(out_div0)
   );

   typedef struct packed {
      logic             v;
      logic [DW-1:0]    q;
      logic [SW-1:0]    r;
      logic [TAG_W-1:0] t;
      logic             z;
   } res_t;

   res_t pipe[$];
   res_t exp_r = '0;
   bit   exp_rst = 1'b1;
   bit   live = 1'b0;
   int   passed = 0;
   int   total = 0;

   function automatic res_t model(input logic v, input int dvd, input int dvs, input int tag);
      res_t m;
      int   q, r;
      if (dvs == 0) begin
         q = (1 << DW) - 1;
         r = dvd % (1 << SW);
      end else begin
         q = dvd / dvs;
         r = dvd % dvs;
`ifdef QNR_ROUND_EN
         if (2 * r >= dvs && q < (1 << DW) - 1) q = q + 1;
`endif
      end
      m.v = v;
      m.q = q[DW-1:0];
      m.r = r[SW-1:0];
      m.t = tag[TAG_W-1:0];
      m.z = (dvs == 0);
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
   endtask

   // Reference: each ena-high edge admits one record; it emerges LAT-1 ena-high edges later.
   always @(posedge clk) begin
      if (!rst_n) begin
         pipe.delete();
         for (int i = 0; i < LAT - 1; i++) pipe.push_back('0);
         exp_r   = '0;
         exp_rst = 1'b1;
      end else if (ena) begin
         pipe.push_back(model(in_valid, int'(in_dividend), int'(in_divisor), int'(in_tag)));
         exp_r   = pipe.pop_front();
         exp_rst = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         check("model_valid", {31'b0, out_valid}, {31'b0, exp_r.v});
         if (exp_r.v || exp_rst) begin
            check("model_quotient", 32'(out_quotient), 32'(exp_r.q));
            check("model_remainder", 32'(out_remainder), 32'(exp_r.r));
            check("model_tag", 32'(out_tag), 32'(exp_r.t));
            check("model_div0", {31'b0, out_div0}, {31'b0, exp_r.z});
         end
      end
   end

   task automatic drive(input logic v, input int dvd, input int dvs, input int tag);
      in_valid    = v;
      in_dividend = dvd[DW-1:0];
      in_divisor  = dvs[SW-1:0];
      in_tag      = tag[TAG_W-1:0];
      @(posedge clk);
      #1;
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 1, 0);
   endtask

   task automatic check_result(input string name, input int q, input int r, input int tag, input logic z);
      check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({name, "_q"}, 32'(out_quotient), q);
      check({name, "_r"}, 32'(out_remainder), r);
      check({name, "_tag"}, 32'(out_tag), tag);
      check({name, "_div0"}, {31'b0, out_div0}, {31'b0, z});
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      @(posedge clk);
      #1;
      live = 1'b1;
      check("reset_valid", {31'b0, out_valid}, 32'd0);
      check("reset_q", 32'(out_quotient), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic: 200/7
      drive(1'b1, 200, 7, 3);
      bubbles(LAT - 2);
      check("basic_early_valid", {31'b0, out_valid}, 32'd0);
      bubbles(1);
`ifdef QNR_ROUND_EN
      check_result("basic", 29, 4, 3, 1'b0);
`else
      check_result("basic", 28, 4, 3, 1'b0);
`endif
      bubbles(2);

      // Streaming, checked by the model
      drive(1'b1, 255, 1, 1);
      drive(1'b1, 255, 255, 2);
      drive(1'b1, 0, 5, 3);
      drive(1'b1, 100, 10, 4);
      bubbles(LAT - 4);
      check_result("stream0", 255, 0, 1, 1'b0);
      bubbles(1);
      check_result("stream1", 1, 0, 2, 1'b0);
      bubbles(1);
      check_result("stream2", 0, 0, 3, 1'b0);
      bubbles(1);
      check_result("stream3", 10, 0, 4, 1'b0);
      bubbles(2);

      // Stall with in_valid pulsed while ena is low
      drive(1'b1, 150, 4, 5);
      bubbles(2);
      ena = 1'b0;
      drive(1'b1, 99, 9, 9);
      drive(1'b0, 0, 1, 0);
      drive(1'b1, 33, 3, 10);
      ena = 1'b1;
      bubbles(LAT - 4);
      check("stall_early_valid", {31'b0, out_valid}, 32'd0);
      bubbles(1);
`ifdef QNR_ROUND_EN
      check_result("stall", 38, 2, 5, 1'b0);
`else
      check_result("stall", 37, 2, 5, 1'b0);
`endif
      bubbles(3);

      // Divide by zero next to a normal op
      drive(1'b1, 77, 0, 6);
      drive(1'b1, 77, 3, 7);
      bubbles(LAT - 2);
      check_result("div0", 255, 77, 6, 1'b1);
      bubbles(1);
`ifdef QNR_ROUND_EN
      check_result("div0_neighbour", 26, 2, 7, 1'b0);
`else
      check_result("div0_neighbour", 25, 2, 7, 1'b0);
`endif
      bubbles(2);

`ifdef QNR_ROUND_EN
      drive(1'b1, 255, 1, 1);
      drive(1'b1, 9, 2, 2);
      drive(1'b1, 5, 4, 3);
      bubbles(LAT - 3);
      check_result("round_sat", 255, 0, 1, 1'b0);
      bubbles(1);
      check_result("round_9_2", 5, 1, 2, 1'b0);
      bubbles(1);
      check_result("round_5_4", 1, 1, 3, 1'b0);
      bubbles(2);
`endif

      // Reset mid-flight
      drive(1'b1, 10, 3, 1);
      drive(1'b1, 20, 3, 2);
      drive(1'b1, 30, 3, 3);
      bubbles(1);
      rst_n = 1'b0;
      drive(1'b0, 0, 1, 0);
      check("midrst_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_q", 32'(out_quotient), 32'd0);
      check("midrst_r", 32'(out_remainder), 32'd0);
      check("midrst_tag", 32'(out_tag), 32'd0);
      check("midrst_div0", {31'b0, out_div0}, 32'd0);
      rst_n = 1'b1;
      bubbles(LAT + 2);

      // Randomised traffic with stalls, zero/extreme divisors and rare resets
      for (int i = 0; i < 600; i++) begin
         int sel;
         int dvs;
         sel = int'($urandom_range(0, 5));
         case (sel)
            0:       dvs = 0;
            1:       dvs = 1;
            2:       dvs = (1 << SW) - 1;
            default: dvs = int'($urandom_range(1, (1 << SW) - 1));
         endcase
         ena   = ($urandom_range(0, 7) != 0);
         rst_n = ($urandom_range(0, 149) != 0);
         drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, (1 << DW) - 1)), dvs,
               int'($urandom_range(0, (1 << TAG_W) - 1)));
      end
      rst_n = 1'b1;
      ena   = 1'b1;
      bubbles(LAT + 2);

      live = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
